// File: rtl/cache_lookup_ctrl_if.sv
// rtl/cache_lookup_ctrl_if.sv - request, response and refill signals of cache_lookup_ctrl
interface cache_lookup_ctrl_if #(
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 5,
    parameter int BYTE_W   = 2
);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WSEL_W = OFFSET_W - BYTE_W;

    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic                inv_all;
    logic                resp_valid;
    logic                resp_hit;
    logic [TAG_W-1:0]    resp_tag;
    logic [INDEX_W-1:0]  resp_index;
    logic [WSEL_W-1:0]   resp_word_sel;
    logic [BYTE_W-1:0]   resp_byte_off;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                fill_done;

    modport master (
        output req_valid, req_addr, inv_all, mem_req_ready, fill_done,
        input  req_ready, resp_valid, resp_hit, resp_tag, resp_index,
               resp_word_sel, resp_byte_off, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  req_valid, req_addr, inv_all, mem_req_ready, fill_done,
        output req_ready, resp_valid, resp_hit, resp_tag, resp_index,
               resp_word_sel, resp_byte_off, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/cache_lookup_ctrl.sv
// rtl/cache_lookup_ctrl.sv - registered direct-mapped cache lookup with line-refill handshake
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_lookup_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 5,
    parameter int BYTE_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    cache_lookup_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
`endif
);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WSEL_W = OFFSET_W - BYTE_W;
    localparam int LINES  = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_store [LINES];
    logic                resp_hit_q;
    logic [TAG_W-1:0]    resp_tag_q;
    logic [INDEX_W-1:0]  resp_index_q;
    logic [WSEL_W-1:0]   resp_word_sel_q;
    logic [BYTE_W-1:0]   resp_byte_off_q;

    logic [TAG_W-1:0]    tag_a;
    logic [INDEX_W-1:0]  idx_a;
    logic                accept, lookup_hit, fill_fire, resp_load;

    assign tag_a      = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_a      = addr_q[OFFSET_W +: INDEX_W];
    assign accept     = bus.req_valid && (state_q == IDLE) && !bus.inv_all;
    assign lookup_hit = valid_q[idx_a] && (tag_store[idx_a] == tag_a);
    assign fill_fire  = (state_q == MISS_WAIT) && bus.fill_done;
    assign resp_load  = ((state_q == LOOKUP) && lookup_hit) || fill_fire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LOOKUP;
            LOOKUP:    state_d = lookup_hit ? RESP : MISS_REQ;
            MISS_REQ:  if (bus.mem_req_ready) state_d = MISS_WAIT;
            MISS_WAIT: if (bus.fill_done) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            valid_q         <= '0;
            resp_hit_q      <= 1'b0;
            resp_tag_q      <= '0;
            resp_index_q    <= '0;
            resp_word_sel_q <= '0;
            resp_byte_off_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) addr_q <= bus.req_addr;
            if ((state_q == IDLE) && bus.inv_all) valid_q <= '0;
            else if (fill_fire) valid_q[idx_a] <= 1'b1;
            // Response fields only move when a response is produced, so they hold between pulses.
            if (resp_load) begin
                resp_hit_q      <= (state_q == LOOKUP);
                resp_tag_q      <= tag_a;
                resp_index_q    <= idx_a;
                resp_word_sel_q <= addr_q[BYTE_W +: WSEL_W];
                resp_byte_off_q <= addr_q[BYTE_W-1:0];
            end
        end
    end

    // Tag contents are meaningless until the matching valid bit is set, so no reset here.
    always_ff @(posedge clk) begin
        if (fill_fire) tag_store[idx_a] <= tag_a;
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == RESP) begin
            if (resp_hit_q) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

    assign bus.req_ready     = (state_q == IDLE) && !bus.inv_all;
    assign bus.resp_valid    = (state_q == RESP);
    assign bus.resp_hit      = resp_hit_q;
    assign bus.resp_tag      = resp_tag_q;
    assign bus.resp_index    = resp_index_q;
    assign bus.resp_word_sel = resp_word_sel_q;
    assign bus.resp_byte_off = resp_byte_off_q;
    assign bus.mem_req_valid = (state_q == MISS_REQ);
    assign bus.mem_req_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// tb/tb_cache_lookup_ctrl.sv - randomized bench for cache_lookup_ctrl against a tag-array model
module tb_cache_lookup_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_lookup_ctrl_if #(.ADDR_W(16), .INDEX_W(5), .OFFSET_W(5), .BYTE_W(2)) bus ();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_lookup_ctrl #(.ADDR_W(16), .INDEX_W(5), .OFFSET_W(5), .BYTE_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    bit ref_valid [32];
    int ref_tag   [32];
    int ref_hits, ref_misses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic model_inv();
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic do_req(input int a, input int stall, input int fill_gap);
        int t, ix, w, b;
        bit hit;
        t   = a / 1024;
        ix  = (a / 32) % 32;
        w   = (a / 4) % 8;
        b   = a % 4;
        hit = ref_valid[ix] && (ref_tag[ix] == t);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a[15:0];
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("lookup_no_resp", bus.resp_valid, 0);
        chk("lookup_no_memreq", bus.mem_req_valid, 0);
        if (!hit) begin
            @(negedge clk);
            for (int i = 0; i < stall; i++) begin
                chk("stall_mem_req_valid", bus.mem_req_valid, 1);
                chk("stall_mem_req_addr", bus.mem_req_addr, a - (a % 32));
                bus.fill_done = 1'($urandom % 2);
                @(negedge clk);
                chk("stall_no_resp", bus.resp_valid, 0);
            end
            bus.fill_done = 1'b0;
            chk("mem_req_valid", bus.mem_req_valid, 1);
            chk("mem_req_addr", bus.mem_req_addr, a - (a % 32));
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            chk("mem_req_drop", bus.mem_req_valid, 0);
            for (int i = 0; i < fill_gap; i++) begin
                bus.mem_req_ready = 1'($urandom % 2);
                @(negedge clk);
                chk("wait_no_resp", bus.resp_valid, 0);
            end
            bus.mem_req_ready = 1'b0;
            bus.fill_done     = 1'b1;
            @(negedge clk);
            bus.fill_done = 1'b0;
        end else begin
            @(negedge clk);
        end
        chk("resp_valid", bus.resp_valid, 1);
        chk("resp_hit", bus.resp_hit, hit);
        chk("resp_tag", bus.resp_tag, t);
        chk("resp_index", bus.resp_index, ix);
        chk("resp_word_sel", bus.resp_word_sel, w);
        chk("resp_byte_off", bus.resp_byte_off, b);
        ref_valid[ix] = 1'b1;
        ref_tag[ix]   = t;
        if (hit) ref_hits++;
        else     ref_misses++;
        @(negedge clk);
        chk("resp_one_cycle", bus.resp_valid, 0);
    endtask

    task automatic do_inv();
        bus.inv_all   = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'($urandom);
        #1;
        chk("inv_req_ready", bus.req_ready, 0);
        @(negedge clk);
        bus.inv_all   = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("inv_not_accepted", bus.req_ready, 1);
        chk("inv_no_memreq", bus.mem_req_valid, 0);
        model_inv();
        @(negedge clk);
        chk("inv_no_resp", bus.resp_valid, 0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.inv_all       = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.fill_done     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_hit", bus.resp_hit, 0);
        chk("rst_resp_tag", bus.resp_tag, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        do_req('hABCD, 2, 1);
        do_req('hABD0, 0, 0);
        do_req('hABCD, 0, 0);
        do_req('h2BCD, 0, 2);
        do_req('hABCD, 0, 0);
`ifdef CACHE_STATS_EN
        chk("hit_cnt_directed", hit_cnt, 2);
        chk("miss_cnt_directed", miss_cnt, 3);
`endif
        do_req('hFFFF, 10, 0);
        do_req('h0000, 0, 0);

        do_inv();
        do_req('hABCD, 0, 0);

        do_inv();
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h1234;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_mem_req_valid", bus.mem_req_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_abort_resp_valid", bus.resp_valid, 0);
        chk("rst_abort_resp_tag", bus.resp_tag, 0);
        model_reset();
        @(negedge clk);
        chk("rst_abort_no_resp", bus.resp_valid, 0);
`ifdef CACHE_STATS_EN
        chk("hit_cnt_after_rst", hit_cnt, 0);
`endif

        for (int n = 0; n < 80; n++) begin
            if ($urandom % 10 == 0) begin
                do_inv();
            end else begin
                int a;
                a = int'($urandom % 4) * 1024 + int'($urandom % 4) * 32 + int'($urandom % 32);
                do_req(a, int'($urandom % 4), int'($urandom % 3));
            end
        end

`ifdef CACHE_STATS_EN
        chk("hit_cnt_final", hit_cnt, ref_hits);
        chk("miss_cnt_final", miss_cnt, ref_misses);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
